issue_ctrl: RTL

Dual-issue hazard scheduler between decode and exec. Holds a per-register scoreboard and the single memory port and long-latency unit. Each cycle it decides whether the upper slot, the lower slot, both, or neither may issue. It drives the pipeline stall that fetch and decode use as their interlock, and splits a pair across two cycles when the two slots conflict.

---
 rtl/issue_pkg.sv | 26 ++
 rtl/issue_ctrl_if.sv | 31 +++
 rtl/issue_scoreboard.sv | 90 +++++++++
 rtl/issue_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and default latencies for the dual-issue hazard scheduler.
package issue_pkg;

  localparam int NREG_DEF     = 32;
  localparam int LOAD_LAT_DEF = 2;
  localparam int ALU_LAT_DEF  = 1;
  localparam int CNT_W_DEF    = 2;
  localparam int RW           = 5;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_LONG  = 2'd2,
    CLS_STORE = 2'd3
  } cls_e;

  typedef enum logic {
    ST_PAIR    = 1'b0,
    ST_SPLIT_L = 1'b1
  } state_e;

  function automatic logic is_mem(cls_e c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode-pair, long-unit completion and issue/stall signals between decode and the scheduler.
interface issue_ctrl_if;
  import issue_pkg::*;

  logic          flush;
  logic          u_valid, l_valid;
  logic [RW-1:0] u_rs1, u_rs2, l_rs1, l_rs2;
  logic          u_rs1_used, u_rs2_used, l_rs1_used, l_rs2_used;
  logic [RW-1:0] u_rd, l_rd;
  logic          u_rd_used, l_rd_used;
  cls_e          u_class, l_class;
  logic          long_done;
  logic [RW-1:0] long_rd;
  logic          u_issue, l_issue, stall;
  logic [31:0]   stall_cycles;

  modport master (
    output flush, u_valid, l_valid, u_rs1, u_rs2, l_rs1, l_rs2,
           u_rs1_used, u_rs2_used, l_rs1_used, l_rs2_used,
           u_rd, l_rd, u_rd_used, l_rd_used, u_class, l_class, long_done, long_rd,
    input  u_issue, l_issue, stall, stall_cycles
  );

  modport slave (
    input  flush, u_valid, l_valid, u_rs1, u_rs2, l_rs1, l_rs2,
           u_rs1_used, u_rs2_used, l_rs1_used, l_rs2_used,
           u_rd, l_rd, u_rd_used, l_rd_used, u_class, l_class, long_done, long_rd,
    output u_issue, l_issue, stall, stall_cycles
  );

endinterface

// File: rtl/issue_scoreboard.sv
// Per-register result countdowns plus long-unit pending bits; answers "is this source ready".
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int ALU_LAT  = ALU_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0][RW-1:0]   src_idx,
  output logic [3:0]           src_rdy,
  input  logic [RW-1:0]        u_rd,
  input  logic [RW-1:0]        l_rd,
  output logic                 u_rd_pend,
  output logic                 l_rd_pend,
  output logic                 long_busy,
  input  logic                 u_set,
  input  cls_e                 u_cls,
  input  logic                 l_set,
  input  cls_e                 l_cls,
  input  logic                 long_done,
  input  logic [RW-1:0]        long_rd
);

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]            pend_q, pend_d;
  logic                       busy_q, busy_d;
  logic [1:0]                 set_v;
  logic [1:0][RW-1:0]         set_rd;
  cls_e                       set_cls [2];

  assign set_v      = {l_set, u_set};
  assign set_rd     = {l_rd, u_rd};
  assign set_cls[0] = u_cls;
  assign set_cls[1] = l_cls;

  assign u_rd_pend = pend_q[u_rd];
  assign l_rd_pend = pend_q[l_rd];
  assign long_busy = busy_q;

  // Source lookup
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      src_rdy[i] = (cnt_q[src_idx[i]] == '0) && !pend_q[src_idx[i]];
    end
  end

  // Countdown, completion clear, then issue sets (sets override both)
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - CNT_W'(1)) : cnt_q[r];
    end
    if (long_done) begin
      pend_d[long_rd] = 1'b0;
      busy_d          = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    for (int s = 0; s < 2; s++) begin
      case (set_v[s] ? set_cls[s] : CLS_STORE)
        CLS_ALU:  cnt_d[set_rd[s]] = CNT_W'(ALU_LAT - 1);
        CLS_LOAD: cnt_d[set_rd[s]] = CNT_W'(LOAD_LAT - 1);
        CLS_LONG: begin
          pend_d[set_rd[s]] = 1'b1;
          busy_d            = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scoreboard state register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue hazard scheduler: decides upper/lower issue each cycle, splits conflicting
// pairs over two cycles and drives the fetch/decode stall plus a saturating stall counter.
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int ALU_LAT  = ALU_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  issue_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic               warm_q;
  logic               rst_q;
  logic [31:0]        stall_cycles_q, stall_cycles_d;
  logic [3:0][RW-1:0] src_idx;
  logic [3:0]         src_rdy;
  logic               u_rd_pend, l_rd_pend, long_busy;
  logic               u_blk, l_blk, pair_conf;
  logic               u_issue_s, l_issue_s, stall_s;

  assign src_idx = {bus.l_rs2, bus.l_rs1, bus.u_rs2, bus.u_rs1};

  issue_scoreboard #(
    .NREG(NREG), .LOAD_LAT(LOAD_LAT), .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)
  ) u_sb (
    .clk(clk), .rst(rst),
    .src_idx(src_idx), .src_rdy(src_rdy),
    .u_rd(bus.u_rd), .l_rd(bus.l_rd),
    .u_rd_pend(u_rd_pend), .l_rd_pend(l_rd_pend), .long_busy(long_busy),
    .u_set(u_issue_s && bus.u_rd_used), .u_cls(bus.u_class),
    .l_set(l_issue_s && bus.l_rd_used), .l_cls(bus.l_class),
    .long_done(bus.long_done), .long_rd(bus.long_rd)
  );

  assign u_blk = (bus.u_rs1_used && !src_rdy[0]) || (bus.u_rs2_used && !src_rdy[1]) ||
                 ((bus.u_class == CLS_LONG) && (long_busy || (bus.u_rd_used && u_rd_pend)));
  assign l_blk = (bus.l_rs1_used && !src_rdy[2]) || (bus.l_rs2_used && !src_rdy[3]) ||
                 ((bus.l_class == CLS_LONG) && (long_busy || (bus.l_rd_used && l_rd_pend)));

  assign pair_conf = (bus.u_rd_used && ((bus.l_rs1_used && (bus.l_rs1 == bus.u_rd)) ||
                                        (bus.l_rs2_used && (bus.l_rs2 == bus.u_rd)))) ||
                     (bus.u_rd_used && bus.l_rd_used && (bus.l_rd == bus.u_rd)) ||
                     (is_mem(bus.u_class) && is_mem(bus.l_class)) ||
                     ((bus.u_class == CLS_LONG) && (bus.l_class == CLS_LONG));

  // Issue decision and next state
  always_comb begin
    state_d   = state_q;
    u_issue_s = 1'b0;
    l_issue_s = 1'b0;
    stall_s   = 1'b0;
    if (rst || warm_q) begin
      stall_s = 1'b1;
      state_d = ST_PAIR;
    end else if (bus.flush) begin
      state_d = ST_PAIR;
    end else begin
      case (state_q)
        ST_PAIR: begin
          if (bus.u_valid) begin
            if (u_blk) begin
              stall_s = 1'b1;
            end else if (bus.l_valid && (l_blk || pair_conf)) begin
              u_issue_s = 1'b1;
              stall_s   = 1'b1;
              state_d   = ST_SPLIT_L;
            end else begin
              u_issue_s = 1'b1;
              l_issue_s = bus.l_valid;
            end
          end else begin
            l_issue_s = bus.l_valid && !l_blk;
            stall_s   = bus.l_valid && l_blk;
          end
        end
        ST_SPLIT_L: begin
          if (bus.l_valid && l_blk) begin
            stall_s = 1'b1;
          end else begin
            l_issue_s = bus.l_valid;
            state_d   = ST_PAIR;
          end
        end
        default: state_d = ST_PAIR;
      endcase
    end
  end

  // Stall counter: stall is high throughout reset, so reset restarts the count at 1 on its
  // first cycle and keeps counting while it is held.
  always_comb begin
    if (rst) begin
      if (rst_q == 1'b1) begin
        stall_cycles_d = (stall_cycles_q == 32'hFFFF_FFFF) ? stall_cycles_q : stall_cycles_q + 32'd1;
      end else begin
        stall_cycles_d = 32'd1;
      end
    end else if (stall_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Control state, warm-up flag and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PAIR;
      warm_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      warm_q  <= 1'b0;
    end
    stall_cycles_q <= stall_cycles_d;
  end

  // Previous-cycle reset, used to find the first reset cycle
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  assign bus.u_issue      = u_issue_s;
  assign bus.l_issue      = l_issue_s;
  assign bus.stall        = stall_s;
  assign bus.stall_cycles = stall_cycles_q;

endmodule
